// File: rtl/parity_pkg.sv
// Shared types for the serial parity stage.
// State encoding and bit_count width helper.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/Xor_gate.sv
// Two-input XOR cell used in the parity accumulator feedback.
module Xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial parity stage: running XOR over a data frame,
// then compare against the trailing received parity bit.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           bit_in,
  input  logic                           bit_valid,
  output logic                           busy,
  output logic [cnt_width(DATA_BITS)-1:0] bit_count,
  output logic                           frame_done,
  output logic                           parity_out,
  output logic                           parity_err
);

  localparam int CW = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  state_t        state;
  state_t        state_nx;
  logic          acc;
  logic          acc_nx;
  logic          acc_x;
  logic [CW-1:0] cnt_nx;
  logic          pout_nx;
  logic          perr_nx;

  // acc_x doubles as the parity compare in PAR
  Xor_gate u_xor (
    .a (acc),
    .b (bit_in),
    .y (acc_x)
  );

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = bit_count;
    pout_nx  = parity_out;
    perr_nx  = parity_err;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = DATA;
          acc_nx   = ODD_PARITY;
          cnt_nx   = '0;
        end
      end
      DATA: begin
        if (bit_valid) begin
          acc_nx = acc_x;
          cnt_nx = bit_count + 1'b1;
          if (bit_count == LAST)
            state_nx = PAR;
        end
      end
      PAR: begin
        if (bit_valid) begin
          pout_nx  = acc;
          perr_nx  = acc_x;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_nx = DATA;
          acc_nx   = ODD_PARITY;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= 1'b0;
      bit_count  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      parity_out <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_nx;
      acc        <= acc_nx;
      bit_count  <= cnt_nx;
      busy       <= (state_nx == DATA) || (state_nx == PAR);
      frame_done <= (state_nx == DONE);
      parity_out <= pout_nx;
      parity_err <= perr_nx;
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench: even and odd instances share one stimulus
// stream; expectations are hand-computed per frame.
module tb_serial_parity_checker;

  logic clk;
  logic rst_n;
  logic start;
  logic bit_in;
  logic bit_valid;

  logic       e_busy, e_done, e_pout, e_perr;
  logic [3:0] e_cnt;
  logic       o_busy, o_done, o_pout, o_perr;
  logic [3:0] o_cnt;

  int n_chk;
  int n_fail;
  int cyc;
  int t0;

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b0)) u_even (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .busy       (e_busy),
    .bit_count  (e_cnt),
    .frame_done (e_done),
    .parity_out (e_pout),
    .parity_err (e_perr)
  );

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b1)) u_odd (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .busy       (o_busy),
    .bit_count  (o_cnt),
    .frame_done (o_done),
    .parity_out (o_pout),
    .parity_err (o_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    t0 = cyc;
    start = 1'b0;
  endtask

  // bits sent d[7] first; gaps of 3 idle cycles after listed bits
  task automatic send_bits(input logic [7:0] d, input int gap_a,
                           input int gap_b);
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1;
      bit_in    = d[7-i];
      step();
      bit_valid = 1'b0;
      if (i + 1 == gap_a || i + 1 == gap_b)
        repeat (3) step();
    end
  endtask

  task automatic send_par(input logic p);
    bit_valid = 1'b1;
    bit_in    = p;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int lat,
                             input logic ep, input logic ee,
                             input logic op, input logic oe);
    check({tag, "_done"}, {o_done, e_done}, 2'b11);
    check({tag, "_lat"}, cyc - t0, lat);
    check({tag, "_cnt"}, e_cnt, 4'd8);
    check({tag, "_busy"}, {o_busy, e_busy}, 2'b00);
    check({tag, "_e"}, {e_pout, e_perr}, {ep, ee});
    check({tag, "_o"}, {o_pout, o_perr}, {op, oe});
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    t0 = 0;
    rst_n = 1'b0;
    start = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    #1;
    check("rst", {e_busy, e_done, e_pout, e_perr, e_cnt}, 8'h00);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("idle", {o_busy, o_done, o_pout, o_perr, o_cnt}, 8'h00);

    // four ones, parity 0: even clean, odd mismatch
    do_start();
    check("f1_busy", e_busy, 1'b1);
    send_bits(8'b1011_0010, 0, 0);
    check("f1_par_busy", {e_busy, e_done, e_cnt}, 6'b1_0_1000);
    send_par(1'b0);
    check_frame("f1", 9, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("f1_pulse", e_done, 1'b0);
    check("f1_hold", {e_pout, e_perr, e_cnt}, 6'b0_0_1000);

    // same data, parity 1
    do_start();
    send_bits(8'b1011_0010, 0, 0);
    send_par(1'b1);
    check_frame("f2", 9, 1'b0, 1'b1, 1'b1, 1'b0);
    step();

    // all ones with gaps after bits 2 and 5: six extra cycles
    do_start();
    send_bits(8'hFF, 2, 5);
    send_par(1'b1);
    check_frame("f3", 15, 1'b0, 1'b1, 1'b1, 1'b0);
    step();

    // reset after four data bits
    do_start();
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in = 1'b1;
      step();
    end
    bit_valid = 1'b0;
    check("mid_cnt", e_cnt, 4'd4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_e", {e_busy, e_done, e_pout, e_perr, e_cnt}, 8'h00);
    check("mid_rst_o", {o_busy, o_done, o_pout, o_perr, o_cnt}, 8'h00);
    step();
    rst_n = 1'b1;
    repeat (12) begin
      step();
      if (e_done || o_done)
        check("no_done", {o_done, e_done}, 2'b00);
    end
    check("post_rst", {e_busy, e_done, o_busy, o_done}, 4'h0);

    // fresh frame after reset
    do_start();
    send_bits(8'b1011_0010, 0, 0);
    send_par(1'b0);
    check_frame("f4", 9, 1'b0, 1'b0, 1'b1, 1'b1);

    // back-to-back start in the DONE cycle
    do_start();
    check("b2b", {e_busy, e_done, e_cnt}, 6'b1_0_0000);
    check("b2b_hold", {e_pout, o_pout, o_perr}, 3'b011);
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1;
      bit_in = (i == 7);
      start = (i == 3);
      step();
      start = 1'b0;
      if (i == 3)
        check("ign_start", {e_busy, e_cnt}, 5'b1_0100);
    end
    bit_valid = 1'b0;
    check("f5_cnt", e_cnt, 4'd8);
    send_par(1'b1);
    check_frame("f5", 9, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check("f5_idle", {e_busy, e_done}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
